// File: rtl/lut_neuron_loader.sv
// LUT neuron with streamed table loading.
// A 2^IN_BITS x OUT_BITS lookup table is filled by B config beats of E entries each.
// Once a framed load completes, lookups return table[M0] with one cycle of latency.
module lut_neuron_loader #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 2,
  parameter int CFG_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CFG_BITS-1:0] cfg_data,
  input  logic                cfg_last,
  input  logic [IN_BITS-1:0]  M0,
  input  logic                in_valid,
  output logic [OUT_BITS-1:0] M1,
  output logic                out_valid,
  output logic                loaded,
  output logic                cfg_err
);

  localparam int E     = CFG_BITS / OUT_BITS;
  localparam int DEPTH = 1 << IN_BITS;
  localparam int B     = DEPTH / E;
  localparam int CW    = (B > 1) ? $clog2(B) : 1;

  typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [OUT_BITS-1:0] lut [DEPTH];

  logic [CW-1:0]       idx;
  logic                beat_end;
  logic                frame_err;
  logic                wr_en;

  // Every beat is accepted the cycle it is offered.
  assign cfg_ready = 1'b1;

  // Beat index and framing check.
  // A beat that arrives outside LOAD always starts a new table, so it is beat 0.
  always_comb begin
    idx       = (state == LOAD) ? cnt : '0;
    beat_end  = (idx == CW'(B - 1));
    frame_err = cfg_valid && (cfg_last != beat_end);
    wr_en     = rst && cfg_valid && !frame_err;
  end

  // Table storage.
  // It has no reset.
  // A framing-error beat is discarded and is not written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < E; k++)
        lut[IN_BITS'(idx) * IN_BITS'(E) + IN_BITS'(k)] <= cfg_data[k*OUT_BITS +: OUT_BITS];
    end
  end

  // Control FSM plus registered lookup path.
  // The lookup reads the pre-write table when it collides with a beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= EMPTY;
      cnt       <= '0;
      M1        <= '0;
      out_valid <= 1'b0;
      loaded    <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      if (state == RUN && in_valid) begin
        M1        <= lut[M0];
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end

      if (cfg_valid) begin
        if (frame_err) begin
          state   <= EMPTY;
          cnt     <= '0;
          cfg_err <= 1'b1;
          loaded  <= 1'b0;
        end else if (beat_end) begin
          state  <= RUN;
          cnt    <= '0;
          loaded <= 1'b1;
        end else begin
          // Entering LOAD consumes beat 0, so the counter points at beat 1 next.
          state  <= LOAD;
          cnt    <= idx + CW'(1);
          loaded <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lut_neuron_loader.sv
// Directed self-checking bench for lut_neuron_loader (default parameters: E=4, B=64).
module tb_lut_neuron_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_data;
  logic       cfg_last;
  logic [7:0] M0;
  logic       in_valid;
  logic [1:0] M1;
  logic       out_valid;
  logic       loaded;
  logic       cfg_err;

  int n_assert = 0;
  int n_fail   = 0;

  lut_neuron_loader dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_last  (cfg_last),
    .M0        (M0),
    .in_valid  (in_valid),
    .M1        (M1),
    .out_valid (out_valid),
    .loaded    (loaded),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs and inputs change 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Send n beats of constant data; cfg_last is set on beat last_at (-1 means never).
  task automatic load(input logic [7:0] d, input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = d;
      cfg_last  = (i == last_at);
      tick();
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  // One-cycle lookup with a checked result.
  task automatic lookup(input string tag, input logic [7:0] a, input logic [1:0] exp);
    M0       = a;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_ov"}, 32'(out_valid), 32'd1);
    check({tag, "_m1"}, 32'(M1), 32'(exp));
  endtask

  initial begin
    rst = 1'b0; cfg_valid = 1'b0; cfg_data = '0; cfg_last = 1'b0; M0 = '0; in_valid = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_m1",     32'(M1),        32'd0);
    check("rst_ov",     32'(out_valid), 32'd0);
    check("rst_loaded", 32'(loaded),    32'd0);
    check("rst_err",    32'(cfg_err),   32'd0);
    check("rst_ready",  32'(cfg_ready), 32'd1);
    rst = 1'b1;

    // Lookup in EMPTY is dropped
    M0 = 8'd3; in_valid = 1'b1; tick(); in_valid = 1'b0;
    check("empty_ov", 32'(out_valid), 32'd0);
    check("empty_m1", 32'(M1),        32'd0);

    // Full load of E4, which gives table[a] = a % 4
    load(8'hE4, 1, -1);
    check("load_mid_loaded", 32'(loaded), 32'd0);
    check("load_ready",      32'(cfg_ready), 32'd1);
    load(8'hE4, 63, 62);
    check("full_loaded", 32'(loaded),  32'd1);
    check("full_err",    32'(cfg_err), 32'd0);
    lookup("lk0", 8'd0, 2'd0);
    lookup("lk1", 8'd1, 2'd1);
    lookup("lk2", 8'd2, 2'd2);
    lookup("lk3", 8'd3, 2'd3);
    lookup("lk254", 8'd254, 2'd2);
    tick();
    check("idle_ov", 32'(out_valid), 32'd0);
    check("idle_m1", 32'(M1),        32'd2);

    // All-zero table with a back-to-back sweep
    load(8'h00, 1, -1);
    check("zero_drop_loaded", 32'(loaded), 32'd0);
    load(8'h00, 63, 62);
    check("zero_loaded", 32'(loaded), 32'd1);
    in_valid = 1'b1;
    for (int a = 0; a < 256; a++) begin
      M0 = 8'(a);
      tick();
      check($sformatf("sweep_ov_%0d", a), 32'(out_valid), 32'd1);
      check($sformatf("sweep_m1_%0d", a), 32'(M1),        32'd0);
    end
    in_valid = 1'b0;
    tick();
    check("sweep_end_ov", 32'(out_valid), 32'd0);

    // Reload collision: table[5] = 1, lookup 5 together with an FF beat
    load(8'hE4, 64, 63);
    check("coll_pre_loaded", 32'(loaded), 32'd1);
    M0 = 8'd5; in_valid = 1'b1; cfg_valid = 1'b1; cfg_data = 8'hFF; cfg_last = 1'b0;
    tick();
    in_valid = 1'b0; cfg_valid = 1'b0;
    check("coll_m1",     32'(M1),        32'd1);
    check("coll_ov",     32'(out_valid), 32'd1);
    check("coll_loaded", 32'(loaded),    32'd0);
    // The colliding beat was beat 0, so 63 more beats complete the table
    load(8'hFF, 63, 62);
    check("coll_done_loaded", 32'(loaded), 32'd1);
    lookup("coll_lk5", 8'd5, 2'd3);
    lookup("coll_lk0", 8'd0, 2'd3);

    // Early last on beat 10
    load(8'h00, 11, 10);
    check("early_err",    32'(cfg_err), 32'd1);
    check("early_loaded", 32'(loaded),  32'd0);
    M0 = 8'd6; in_valid = 1'b1; tick(); in_valid = 1'b0;
    check("early_lk_ov", 32'(out_valid), 32'd0);
    check("early_lk_m1", 32'(M1),        32'd3);
    load(8'hE4, 64, 63);
    check("early_reload_loaded", 32'(loaded),  32'd1);
    check("early_reload_err",    32'(cfg_err), 32'd1);
    lookup("early_lk2", 8'd2, 2'd2);

    // Missing last: 64 beats without cfg_last
    load(8'h00, 64, -1);
    check("miss_err",    32'(cfg_err), 32'd1);
    check("miss_loaded", 32'(loaded),  32'd0);
    M0 = 8'd1; in_valid = 1'b1; tick(); in_valid = 1'b0;
    check("miss_lk_ov", 32'(out_valid), 32'd0);
    // The next beat must be beat 0 again, so a clean load frames correctly
    load(8'hE4, 64, 63);
    check("miss_reload_loaded", 32'(loaded), 32'd1);
    lookup("miss_lk3", 8'd3, 2'd3);

    // Reset mid-load, then a clean load of 1B, which gives table[a] = 3 - a % 4
    load(8'hFF, 30, -1);
    rst = 1'b0; tick();
    check("mid_rst_loaded", 32'(loaded),    32'd0);
    check("mid_rst_err",    32'(cfg_err),   32'd0);
    check("mid_rst_m1",     32'(M1),        32'd0);
    check("mid_rst_ov",     32'(out_valid), 32'd0);
    rst = 1'b1;
    load(8'h1B, 64, 63);
    check("mid_loaded", 32'(loaded),  32'd1);
    check("mid_err",    32'(cfg_err), 32'd0);
    lookup("mid_lk0",   8'd0,   2'd3);
    lookup("mid_lk1",   8'd1,   2'd2);
    lookup("mid_lk2",   8'd2,   2'd1);
    lookup("mid_lk3",   8'd3,   2'd0);
    lookup("mid_lk100", 8'd100, 2'd3);
    lookup("mid_lk255", 8'd255, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
